coherence_bus_ctrl: RTL and testbench

Parametrised bus and coherence controller between `CPUS` cache pairs (icache + dcache) and a single memory port. It arbitrates data and instruction requests round-robin and broadcasts snoops with invalidations to every non-requesting dcache. It also services cache-to-cache transfers of Modified words while updating memory in the same transfer. It generalises the two-cache coherence arrangement to N CPUs with an explicit MSI bus transaction FSM.

---
 rtl/coherence_bus_ctrl.sv | 145 ++++++++++++++
 tb/tb_coherence_bus_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl: round-robin MSI bus/snoop controller between CPUS icache/dcache pairs and one memory port.
module coherence_bus_ctrl #(
  parameter int CPUS = 2,
  parameter int WORD_W = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS*WORD_W-1:0] iaddr,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS*WORD_W-1:0] iload,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS*WORD_W-1:0] daddr,
  input  logic [CPUS*WORD_W-1:0] dstore,
  input  logic [CPUS-1:0]        cctrans,
  input  logic [CPUS-1:0]        ccwrite,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS*WORD_W-1:0] dload,
  output logic [CPUS-1:0]        ccwait,
  output logic [CPUS-1:0]        ccinv,
  output logic [CPUS*WORD_W-1:0] ccsnoopaddr,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  logic                   ramwait
);
  localparam int IW = CPUS > 1 ? $clog2(CPUS) : 1;
  localparam int IW1 = IW + 1;
  typedef enum logic [2:0] {IDLE, ARB, SNOOP, SNOOP_RESP, MEM_RD, MEM_WR, C2C, IFETCH} state_t;
  state_t state;
  logic [IW-1:0] dptr, iptr, req, sup, ig;
  logic [WORD_W-1:0] addr;
  logic cw;
  logic [CPUS-1:0] pend_d;
  logic [IW:0] dg, igr, sp;
  // Returns {found, index} of the first set bit at or after ptr, wrapping.
  function automatic logic [IW:0] rr(input logic [CPUS-1:0] p, input logic [IW-1:0] ptr);
    logic [CPUS-1:0] pp;
    logic [IW:0] s;
    rr = '0;
    pp = CPUS'({p, p} >> ptr);
    for (int k = CPUS - 1; k >= 0; k--) begin
      s = {1'b0, ptr} + IW1'(k);
      if (s >= IW1'(CPUS)) s = s - IW1'(CPUS);
      if (pp[k]) rr = {1'b1, s[IW-1:0]};
    end
  endfunction
  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] g);
    logic [IW:0] t;
    t = {1'b0, g} + 1'b1;
    nxt = (t == IW1'(CPUS)) ? '0 : t[IW-1:0];
  endfunction
  assign pend_d = (dREN | dWEN) & ~ccwait;
  assign dg = rr(pend_d, dptr);
  assign igr = rr(iREN, iptr);
  always_comb begin
    sp = '0;
    for (int j = CPUS - 1; j >= 0; j--)
      if (IW'(j) != req && ccwrite[j] && cctrans[j]) sp = {1'b1, IW'(j)};
  end
  always_ff @(posedge CLK)
    if (!nRST) begin
      state <= IDLE;
      dptr <= '0;
      iptr <= '0;
      req <= '0;
      sup <= '0;
      ig <= '0;
      addr <= '0;
      cw <= 1'b0;
    end else
      case (state)
        IDLE:
          if (|pend_d) state <= ARB;
          else if (igr[IW]) begin
            state <= IFETCH;
            ig <= igr[IW-1:0];
            iptr <= nxt(igr[IW-1:0]);
          end
        ARB:
          if (dg[IW]) begin
            req <= dg[IW-1:0];
            dptr <= nxt(dg[IW-1:0]);
            addr <= daddr[dg[IW-1:0]*WORD_W +: WORD_W];
            cw <= ccwrite[dg[IW-1:0]];
            state <= (dWEN[dg[IW-1:0]] && !cctrans[dg[IW-1:0]]) ? MEM_WR : SNOOP;
          end else state <= IDLE;
        SNOOP: state <= SNOOP_RESP;
        SNOOP_RESP: begin
          sup <= sp[IW-1:0];
          state <= sp[IW] ? C2C : MEM_RD;
        end
        MEM_RD, MEM_WR, C2C, IFETCH: if (!ramwait) state <= IDLE;
      endcase
  always_comb begin
    iwait = '1;
    dwait = '1;
    iload = '0;
    dload = '0;
    ccwait = '0;
    ccinv = '0;
    ccsnoopaddr = '0;
    ramREN = 1'b0;
    ramWEN = 1'b0;
    ramaddr = '0;
    ramstore = '0;
    if (state == SNOOP || state == SNOOP_RESP)
      for (int j = 0; j < CPUS; j++)
        if (IW'(j) != req) begin
          ccwait[j] = 1'b1;
          ccinv[j] = cw;
          ccsnoopaddr[j*WORD_W +: WORD_W] = addr;
        end
    if (state == C2C) begin
      ccwait[sup] = 1'b1;
      ramWEN = 1'b1;
      ramaddr = addr;
      ramstore = dstore[sup*WORD_W +: WORD_W];
      dload[req*WORD_W +: WORD_W] = dstore[sup*WORD_W +: WORD_W];
      dwait[req] = ramwait;
      dwait[sup] = ramwait;
    end
    if (state == MEM_RD) begin
      ramREN = 1'b1;
      ramaddr = addr;
      dload[req*WORD_W +: WORD_W] = ramload;
      dwait[req] = ramwait;
    end
    if (state == MEM_WR) begin
      ramWEN = 1'b1;
      ramaddr = addr;
      ramstore = dstore[req*WORD_W +: WORD_W];
      dwait[req] = ramwait;
    end
    if (state == IFETCH) begin
      ramREN = 1'b1;
      ramaddr = iaddr[ig*WORD_W +: WORD_W];
      iload[ig*WORD_W +: WORD_W] = ramload;
      iwait[ig] = ramwait;
    end
  end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb_coherence_bus_ctrl: directed and randomized transactions checked against a transaction-level bus model.
module tb_coherence_bus_ctrl;
  localparam int N = 4;
  localparam int W = 32;
  logic CLK = 1'b0;
  logic nRST;
  logic [N-1:0] iREN, dREN, dWEN, cctrans, ccwrite, iwait, dwait, ccwait, ccinv;
  logic [N*W-1:0] iaddr, daddr, dstore, iload, dload, ccsnoopaddr;
  logic ramREN, ramWEN, ramwait;
  logic [W-1:0] ramaddr, ramstore, ramload;
  int total = 0;
  int bad = 0;
  int dptr_m = 0;
  int iptr_m = 0;
  coherence_bus_ctrl #(.CPUS(N), .WORD_W(W)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .cctrans(cctrans),
    .ccwrite(ccwrite), .dwait(dwait), .dload(dload), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramwait(ramwait)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic clear_in();
    iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramwait = 1'b0;
  endtask
  function automatic int pick(input logic [N-1:0] p, input int ptr);
    pick = -1;
    for (int k = N - 1; k >= 0; k--)
      if (p[(ptr + k) % N]) pick = (ptr + k) % N;
  endfunction
  // Called in an IDLE cycle with the request already driven; returns in the IDLE cycle after release.
  task automatic xact(input int stall);
    logic [N-1:0] pd, ew, ei, ecw, eci;
    logic [N*W-1:0] esa;
    logic [W-1:0] a, edata, estore;
    int g, sup, base, rel;
    bit data, rd, c2c, snoop, active;
    pd = dREN | dWEN;
    sup = -1;
    data = (pd != 0);
    if (data) begin
      g = pick(pd, dptr_m);
      dptr_m = (g + 1) % N;
      rd = !(dWEN[g] && !cctrans[g]);
      a = daddr[g*W +: W];
      if (rd)
        for (int j = N - 1; j >= 0; j--)
          if (j != g && ccwrite[j] && cctrans[j]) sup = j;
      base = rd ? 4 : 2;
    end else begin
      g = pick(iREN, iptr_m);
      iptr_m = (g + 1) % N;
      rd = 1'b0;
      a = iaddr[g*W +: W];
      base = 1;
    end
    c2c = (sup >= 0);
    rel = base + stall;
    estore = c2c ? dstore[sup*W +: W] : dstore[g*W +: W];
    edata = c2c ? dstore[sup*W +: W] : ramload;
    for (int c = 0; c <= rel + 1; c++) begin
      if (c > 0) @(negedge CLK);
      if (c == rel + 1) clear_in();
      ramwait = (c < rel);
      #1;
      ew = '1;
      ei = '1;
      if (c == rel) begin
        if (data) begin
          ew[g] = 1'b0;
          if (c2c) ew[sup] = 1'b0;
        end else ei[g] = 1'b0;
      end
      snoop = data && rd && (c == 2 || c == 3);
      ecw = '0;
      eci = '0;
      esa = '0;
      for (int j = 0; j < N; j++) if (snoop && j != g) begin
        ecw[j] = 1'b1;
        eci[j] = ccwrite[g];
        esa[j*W +: W] = a;
      end
      if (c2c && c >= 4 && c <= rel) ecw[sup] = 1'b1;
      active = (c >= base && c <= rel);
      chk($sformatf("dwait c%0d", c), dwait, ew);
      chk($sformatf("iwait c%0d", c), iwait, ei);
      chk($sformatf("ccwait c%0d", c), ccwait, ecw);
      chk($sformatf("ccinv c%0d", c), ccinv, eci);
      chk($sformatf("ccsnoopaddr c%0d", c), ccsnoopaddr, esa);
      chk($sformatf("ramREN c%0d", c), ramREN, active && (!data || (rd && !c2c)));
      chk($sformatf("ramWEN c%0d", c), ramWEN, active && (c2c || (data && !rd)));
      if (c == rel) begin
        chk("ramaddr", ramaddr, a);
        if (c2c || (data && !rd)) chk("ramstore", ramstore, estore);
        if (data && rd) chk("dload", dload[g*W +: W], edata);
        if (!data) chk("iload", iload[g*W +: W], ramload);
      end
    end
  endtask
  initial begin
    clear_in();
    nRST = 1'b0;
    iREN = '1; dREN = '1; dWEN = '1;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst dwait", dwait, 4'hF);
    chk("rst iwait", iwait, 4'hF);
    chk("rst ramREN", ramREN, 1'b0);
    chk("rst ramWEN", ramWEN, 1'b0);
    chk("rst ccwait", ccwait, 4'h0);
    chk("rst dload", dload, '0);
    clear_in();
    nRST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dWEN = 4'hF;
      for (int j = 0; j < N; j++) begin
        daddr[j*W +: W] = 32'h100 + 32'(j);
        dstore[j*W +: W] = 32'hA000 + 32'(j);
      end
      xact(0);
    end
    dREN[1] = 1'b1; cctrans[1] = 1'b1; ccwrite[1] = 1'b1;
    daddr[1*W +: W] = 32'h40; ramload = 32'hDEAD;
    xact(1);
    dREN[0] = 1'b1; cctrans[0] = 1'b1; daddr[0 +: W] = 32'h80;
    ccwrite[2] = 1'b1; cctrans[2] = 1'b1; dstore[2*W +: W] = 32'hBEEF;
    xact(0);
    iREN[0] = 1'b1; iaddr[0 +: W] = 32'h200; dREN[1] = 1'b1; daddr[1*W +: W] = 32'h300;
    ramload = 32'h1234;
    xact(3);
    iREN[0] = 1'b1; iaddr[0 +: W] = 32'h200; ramload = 32'h5678;
    xact(0);
    dREN[0] = 1'b1; cctrans[0] = 1'b1; daddr[0 +: W] = 32'h80;
    ccwrite[2] = 1'b1; cctrans[2] = 1'b1; dstore[2*W +: W] = 32'hBEEF;
    ramwait = 1'b1;
    repeat (4) @(negedge CLK);
    #1;
    chk("c2c ramWEN", ramWEN, 1'b1);
    chk("c2c ccwait", ccwait, 4'b0100);
    chk("c2c ramstore", ramstore, 32'hBEEF);
    nRST = 1'b0;
    @(negedge CLK);
    #1;
    chk("midrst ramWEN", ramWEN, 1'b0);
    chk("midrst ccwait", ccwait, 4'h0);
    chk("midrst dwait", dwait, 4'hF);
    nRST = 1'b1;
    clear_in();
    dptr_m = 0;
    iptr_m = 0;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) iREN = 4'($urandom_range(1, 15));
      else begin
        dREN = 4'($urandom);
        dWEN = 4'($urandom);
        cctrans = 4'($urandom);
        ccwrite = 4'($urandom);
        dREN = (dREN & ~(dWEN & ~cctrans)) | (dWEN & cctrans);
        if ((dREN | dWEN) == 0) dREN[$urandom_range(0, N - 1)] = 1'b1;
        iREN = 4'($urandom);
      end
      for (int j = 0; j < N; j++) begin
        iaddr[j*W +: W] = $urandom;
        daddr[j*W +: W] = $urandom;
        dstore[j*W +: W] = $urandom;
      end
      ramload = $urandom;
      xact(int'($urandom_range(0, 3)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
